// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the dual-core RAM arbiter: word and RAM status
// types, the arbiter state encoding and the access timeout limit.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERV0 = 2'd1,
    SERV1 = 2'd2
  } arb_state_t;

  localparam logic [7:0] ARB_TIMEOUT = 8'd255;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two core request ports and the single RAM port seen by
// ram_arbiter; slave is the arbiter's view, master the environment's view.
interface ram_arbiter_if;
  import cpu_types_pkg::*;

  logic [1:0] dREN;
  logic [1:0] dWEN;
  word_t      daddr0;
  word_t      daddr1;
  word_t      dstore0;
  word_t      dstore1;
  word_t      dload;
  logic [1:0] dwait;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  ramstate_t  ramstate;
  logic       arb_err;

  modport slave (
    input  dREN, dWEN, daddr0, daddr1, dstore0, dstore1, ramload, ramstate,
    output dload, dwait, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  modport master (
    output dREN, dWEN, daddr0, daddr1, dstore0, dstore1, ramload, ramstate,
    input  dload, dwait, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter letting two cores share one RAM port, no preemption.
// Optional access watchdog enabled by defining ARB_TIMEOUT_EN.
module ram_arbiter
  import cpu_types_pkg::*;
(
  input logic          CLK,
  input logic          nRST,
  ram_arbiter_if.slave bus
);

  arb_state_t state_r;
  arb_state_t state_s;
  logic       last_grant_r;
  logic       last_grant_s;
  logic [1:0] req_s;
  logic       serving_s;
  logic       sel_s;
  logic       access_s;
  logic       timeout_s;

  word_t      dload_s;
  logic [1:0] dwait_s;
  logic       ram_ren_s;
  logic       ram_wen_s;
  word_t      ram_addr_s;
  word_t      ram_store_s;
  logic       arb_err_s;

  assign req_s     = bus.dREN | bus.dWEN;
  assign serving_s = (state_r == SERV0) || (state_r == SERV1);
  assign sel_s     = (state_r == SERV1);
  assign access_s  = serving_s && (bus.ramstate == ACCESS);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_r;

  // Watchdog: restarts while idle, so every service state begins at zero
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_cnt_r <= 8'd0;
    end else if (!serving_s) begin
      tmo_cnt_r <= 8'd0;
    end else if (!access_s && (tmo_cnt_r != ARB_TIMEOUT)) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign timeout_s = serving_s && !access_s && (tmo_cnt_r == ARB_TIMEOUT);
`else
  assign timeout_s = 1'b0;
`endif

  // State and round-robin history
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
    end
  end

  // Grant decision and RAM/core side outputs
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    dload_s      = 32'd0;
    dwait_s      = req_s;
    ram_ren_s    = 1'b0;
    ram_wen_s    = 1'b0;
    ram_addr_s   = 32'd0;
    ram_store_s  = 32'd0;
    arb_err_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (req_s == 2'b11) begin
          state_s = last_grant_r ? SERV0 : SERV1;
        end else if (req_s[0]) begin
          state_s = SERV0;
        end else if (req_s[1]) begin
          state_s = SERV1;
        end else begin
          state_s = IDLE;
        end
      end
      SERV0, SERV1: begin
        ram_addr_s  = sel_s ? bus.daddr1 : bus.daddr0;
        ram_store_s = sel_s ? bus.dstore1 : bus.dstore0;
        ram_wen_s   = bus.dWEN[sel_s];
        ram_ren_s   = bus.dREN[sel_s] & ~bus.dWEN[sel_s];
        // A withdrawn request abandons the access without touching history
        if (!req_s[sel_s]) begin
          state_s = IDLE;
        end else if (access_s) begin
          dwait_s[sel_s] = 1'b0;
          dload_s        = bus.ramload;
          last_grant_s   = sel_s;
          state_s        = IDLE;
        end else if (timeout_s) begin
          dwait_s[sel_s] = 1'b0;
          arb_err_s      = 1'b1;
          last_grant_s   = sel_s;
          state_s        = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bus.dload    = dload_s;
  assign bus.dwait    = dwait_s;
  assign bus.ramREN   = ram_ren_s;
  assign bus.ramWEN   = ram_wen_s;
  assign bus.ramaddr  = ram_addr_s;
  assign bus.ramstore = ram_store_s;
  assign bus.arb_err  = arb_err_s;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic,
// each cycle compared with a behavioural model of the arbitration rules.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: core being served (-1 = nobody), last completed grant, cycles waited
  int m_serv = -1;
  int m_last = 1;
  int m_cnt  = 0;

  int ren_seen = 0;
  int err_seen = 0;
  int dw0_low  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] req;
    logic [1:0] e_dwait;
    word_t      e_addr, e_store, e_load;
    logic       e_ren, e_wen, e_err, to;
    int         n;
    req     = bus.dREN | bus.dWEN;
    e_dwait = req;
    e_addr  = 32'd0;
    e_store = 32'd0;
    e_load  = 32'd0;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_err   = 1'b0;
    if (nRST && m_serv >= 0) begin
      n       = m_serv;
      e_addr  = (n == 1) ? bus.daddr1 : bus.daddr0;
      e_store = (n == 1) ? bus.dstore1 : bus.dstore0;
      e_wen   = bus.dWEN[n];
      e_ren   = bus.dREN[n] && !bus.dWEN[n];
      to      = TO_EN && (m_cnt == 255) && (bus.ramstate != ACCESS);
      if (req[n]) begin
        if (bus.ramstate == ACCESS) begin
          e_load     = bus.ramload;
          e_dwait[n] = 1'b0;
        end else if (to) begin
          e_err      = 1'b1;
          e_dwait[n] = 1'b0;
        end
      end
    end
    check_val("ramREN",   {31'd0, bus.ramREN}, {31'd0, e_ren});
    check_val("ramWEN",   {31'd0, bus.ramWEN}, {31'd0, e_wen});
    check_val("ramaddr",  bus.ramaddr, e_addr);
    check_val("ramstore", bus.ramstore, e_store);
    check_val("dload",    bus.dload, e_load);
    check_val("dwait",    {30'd0, bus.dwait}, {30'd0, e_dwait});
    check_val("arb_err",  {31'd0, bus.arb_err}, {31'd0, e_err});
    if (bus.ramREN) ren_seen++;
    if (bus.arb_err) err_seen++;
    if (req[0] && !bus.dwait[0]) dw0_low++;
  endtask

  task automatic model_update();
    logic [1:0] req;
    req = bus.dREN | bus.dWEN;
    if (!nRST) begin
      m_serv = -1;
      m_last = 1;
      m_cnt  = 0;
    end else if (m_serv < 0) begin
      if (req == 2'b11)  m_serv = 1 - m_last;
      else if (req[0])   m_serv = 0;
      else if (req[1])   m_serv = 1;
      m_cnt = 0;
    end else if (!req[m_serv]) begin
      m_serv = -1;
    end else if (bus.ramstate == ACCESS || (TO_EN && m_cnt == 255)) begin
      m_last = m_serv;
      m_serv = -1;
    end else begin
      m_cnt++;
    end
  endtask

  // Inputs are driven at the falling edge before this is called
  task automatic step();
    #1;
    check_outputs();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic drive(input logic [1:0] ren, input logic [1:0] wen, input ramstate_t rs);
    bus.dREN     = ren;
    bus.dWEN     = wen;
    bus.ramstate = rs;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive(2'b00, 2'b00, FREE);
    @(negedge CLK);
    m_serv = -1;
    m_last = 1;
    m_cnt  = 0;
    nRST   = 1'b1;
  endtask

  initial begin
    nRST        = 1'b0;
    bus.daddr0  = 32'd0;
    bus.daddr1  = 32'd0;
    bus.dstore0 = 32'd0;
    bus.dstore1 = 32'd0;
    bus.ramload = 32'h5555_AAAA;
    drive(2'b11, 2'b00, ACCESS);
    @(negedge CLK);
    // Requests during reset: nothing granted, both cores stalled
    step();
    step();

    // Tie on the first cycle after reset: 0, 1, 0
    nRST = 1'b1;
    bus.daddr0 = 32'h0000_0A00;
    bus.daddr1 = 32'h0000_0B00;
    for (int i = 0; i < 6; i++) begin
      bus.ramload = 32'h1000_0000 + 32'(i);
      step();
    end
    drive(2'b00, 2'b00, FREE);
    step();

    // Core 1 write-wins access, completes and becomes last grant
    bus.dstore1 = 32'h0000_1234;
    drive(2'b10, 2'b10, FREE);
    step();
    step();
    bus.ramstate = ACCESS;
    step();
    drive(2'b00, 2'b00, FREE);
    step();

    // Core 0 withdraws before ACCESS; history must still favour core 0
    drive(2'b01, 2'b00, FREE);
    step();
    bus.ramstate = BUSY;
    step();
    drive(2'b00, 2'b00, BUSY);
    step();
    drive(2'b11, 2'b00, ACCESS);
    step();
    step();
    drive(2'b00, 2'b00, FREE);
    step();

    // Single read: ramREN for three cycles, one completion with RAM data
    do_reset();
    ren_seen    = 0;
    dw0_low     = 0;
    bus.daddr0  = 32'h0000_0100;
    drive(2'b01, 2'b00, FREE);
    step();
    step();
    bus.ramstate = BUSY;
    step();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hDEAD_BEEF;
    #1;
    check_val("read_dload", bus.dload, 32'hDEAD_BEEF);
    step();
    drive(2'b00, 2'b00, FREE);
    step();
    check_val("read_ren_cycles", 32'(ren_seen), 32'd3);
    check_val("read_dwait_low",  32'(dw0_low), 32'd1);

    // Reset in the middle of serving core 1
    drive(2'b10, 2'b00, FREE);
    step();
    drive(2'b11, 2'b00, BUSY);
    step();
    #1;
    check_outputs();
    #1;
    nRST = 1'b0;
    #1;
    check_val("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check_val("rst_ramaddr", bus.ramaddr, 32'd0);
    check_val("rst_dwait", {30'd0, bus.dwait}, 32'd3);
    m_serv = -1;
    m_last = 1;
    m_cnt  = 0;
    @(negedge CLK);
    nRST = 1'b1;
    bus.ramstate = ACCESS;
    step();
    step();
    drive(2'b00, 2'b00, FREE);
    step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(bus.dREN[n] || bus.dWEN[n])) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.dREN[n] = 1'($urandom_range(0, 1));
            bus.dWEN[n] = bus.dREN[n] ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n == 0) begin
              bus.daddr0  = $urandom;
              bus.dstore0 = $urandom;
            end else begin
              bus.daddr1  = $urandom;
              bus.dstore1 = $urandom;
            end
          end
        end else if ($urandom_range(0, 15) == 0) begin
          bus.dREN[n] = 1'b0;
          bus.dWEN[n] = 1'b0;
        end
      end
      bus.ramstate = ramstate_t'($urandom_range(0, 3));
      bus.ramload  = $urandom;
      step();
    end

    // Long stall: watchdog fires once if built in, otherwise never
    do_reset();
    err_seen = 0;
    drive(2'b01, 2'b00, BUSY);
    for (int i = 0; i < 258; i++) step();
    drive(2'b00, 2'b00, FREE);
    step();
`ifdef ARB_TIMEOUT_EN
    check_val("timeout_pulses", 32'(err_seen), 32'd1);
`else
    check_val("timeout_pulses", 32'(err_seen), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge.
REQ-002 SHALL have ports: nRST  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: dREN  in  2  per-core read request, bit n = core n.
REQ-004 SHALL have ports: dWEN  in  2  per-core write request.
REQ-005 SHALL have ports: daddr0, daddr1  in  32 each (word_t)  per-core byte address.
REQ-006 SHALL have ports: dstore0, dstore1  in  32 each  per-core write data.
REQ-007 SHALL have ports: dload  out  32  read data returned to the core being served.
REQ-008 SHALL have ports: dwait  out  2  per-core stall, 1 = access not yet complete.
REQ-009 SHALL have ports: ramREN, ramWEN  out  1 each  RAM strobes.
REQ-010 SHALL have ports: ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-011 SHALL have ports: ramload  in  32  RAM read data.
REQ-012 SHALL have ports: ramstate  in  2 (ramstate_t)  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-013 SHALL have ports: arb_err  out  1  one-cycle timeout pulse; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-014 SHALL treat core n as requesting when dREN[n] | dWEN[n].
REQ-015 SHALL use registered FSM states IDLE, SERV0, SERV1.
REQ-016 IDLE: no request -> IDLE; one request -> SERVn next edge.
REQ-017 IDLE with both requesting -> SERV of the core != last_grant (round-robin).
REQ-018 last_grant SHALL update to n only on successful completion in SERVn.
REQ-019 SERVn SHALL drive ramaddr=daddrn and ramstore=dstoren; ramWEN=dWEN[n]; ramREN=dREN[n] & ~dWEN[n] (write wins).
REQ-020 IDLE SHALL drive ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-021 Completion: in SERVn with ramstate==ACCESS, dwait[n]=0 and dload=ramload that cycle; next state IDLE.
REQ-022 Minimum latency: request at edge t -> RAM strobes at t+1 -> earliest dwait low in cycle t+1.
REQ-023 dload SHALL be 0 outside a completion cycle.
REQ-024 dwait[n] SHALL be 1 while core n requests and is not completing; 0 when core n does not request.
REQ-025 FREE, BUSY and ERROR in SERVn SHALL hold state with strobes asserted.
REQ-026 If core n drops its request in SERVn, go to IDLE next edge, no completion, last_grant unchanged.
REQ-027 The non-served core SHALL wait at least until the current access completes; there is no preemption.

Reset
REQ-028 nRST low SHALL force state=IDLE and last_grant=1 (core 0 wins the first tie) asynchronously.
REQ-029 During reset: ram outputs 0, dload 0, arb_err 0, dwait = requests per REQ-024.
REQ-030 Reset during SERVn SHALL abandon the access; no completion is signalled.

Configuration
REQ-031 Macro ARB_TIMEOUT_EN defined: 8-bit counter, cleared on entry to SERVn, increments each SERVn cycle without ACCESS.
REQ-032 On count 255 without ACCESS, SHALL pulse arb_err=1 and dwait[n]=0 for one cycle, then go to IDLE with last_grant=n.
REQ-033 Macro undefined: no counter; arb_err constant 0; SERVn waits indefinitely.

Structure
REQ-034 word_t and ramstate_t SHALL come from cpu_types_pkg.
REQ-035 arb_state_t (IDLE, SERV0, SERV1) and ARB_TIMEOUT=8'd255 SHALL be added to cpu_types_pkg.
REQ-036 Single module, no sub-modules; the timeout counter is inline under the macro.

Verification
REQ-037 Scenario: core0 dREN, daddr0=0x100; ACCESS 2 cycles later, ramload=0xDEADBEEF -> dload=0xDEADBEEF, dwait[0] low one cycle, ramREN=1 for 3 cycles.
REQ-038 Scenario: both cores request on the first cycle after reset -> core0 served first, then core1; with both still requesting, grants alternate 0,1,0.
REQ-039 Scenario: core1 dREN=dWEN=1, dstore1=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234.
REQ-040 Scenario: core0 drops its request in SERV0 before ACCESS -> IDLE next edge, dwait[0]=0, last_grant unchanged.
REQ-041 Scenario: with ARB_TIMEOUT_EN, ramstate=BUSY for 256 cycles -> arb_err pulses once, dwait low once, FSM returns to IDLE.
REQ-042 Scenario: nRST asserted mid-SERV1 -> ram strobes 0 immediately, state IDLE, core0 wins the next tie.
